mem_responder: RTL

- Memory-side responder for the core's instruction-fetch read ports and load/store read-write port.
- Holds the 256 x 16 TOY main memory in one single-port synchronous RAM.
- Arbitrates one access per cycle among a load port, the read-write port and `RPORTS` read ports.
- Returns data through a hold-until-ready handshake: the master keeps the request stable until `rdy` is high, and `rdata` is valid in that same cycle.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Port bundles between the core's fetch/load-store units and the memory responder.
// Requests are held stable by the master until rdy is seen high.
interface mem_rport;
  logic        val;
  logic [7:0]  addr;
  logic        rdy;
  logic [15:0] rdata;

  modport slave  (input val, addr, output rdy, rdata);
  modport master (output val, addr, input rdy, rdata);
endinterface

interface mem_rwport;
  logic        val;
  logic        wen;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        rdy;
  logic [15:0] rdata;

  modport slave  (input val, wen, addr, wdata, output rdy, rdata);
  modport master (output val, wen, addr, wdata, input rdy, rdata);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one single-port 256x16 RAM shared by a program-load port,
// a read-write port and RPORTS read ports, one access per cycle, hold-until-ready replies.
module mem_responder #(
  parameter int RPORTS = 2
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  mem_rport.slave     r_intf [0:RPORTS-1],
  mem_rwport.slave    rw_intf,
  input  logic        ld_val_i,
  input  logic [7:0]  ld_addr_i,
  input  logic [15:0] ld_data_i,
  output logic        ld_rdy_o
);
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PTR_W  = (RPORTS > 1) ? $clog2(RPORTS) : 1;

  typedef enum logic {IDLE, RESP} state_e;

  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    return PTR_W'(v % RPORTS);
  endfunction

  logic              r_val   [RPORTS];
  logic [ADDR_W-1:0] r_addr  [RPORTS];
  logic              r_rdy   [RPORTS];
  logic [DATA_W-1:0] r_rdata [RPORTS];

  logic              rw_val;
  logic              rw_wen;
  logic [ADDR_W-1:0] rw_addr;
  logic [DATA_W-1:0] rw_wdata;
  logic              rw_rdy;
  logic [DATA_W-1:0] rw_rdata;

  for (genvar g = 0; g < RPORTS; g++) begin : g_rport
    assign r_val[g]        = r_intf[g].val;
    assign r_addr[g]       = r_intf[g].addr;
    assign r_intf[g].rdy   = r_rdy[g];
    assign r_intf[g].rdata = r_rdata[g];
  end

  assign rw_val        = rw_intf.val;
  assign rw_wen        = rw_intf.wen;
  assign rw_addr       = rw_intf.addr;
  assign rw_wdata      = rw_intf.wdata;
  assign rw_intf.rdy   = rw_rdy;
  assign rw_intf.rdata = rw_rdata;

  state_e            rw_state_p1, rw_state_d;
  state_e            r_state_p1 [RPORTS];
  state_e            r_state_d  [RPORTS];
  logic [PTR_W-1:0]  ptr_p1, ptr_d;

  logic [ADDR_W-1:0] rw_addr_p1;
  logic              rw_wen_p1;
  logic [DATA_W-1:0] rw_wdata_p1;
  logic [ADDR_W-1:0] r_addr_p1 [RPORTS];

  logic [DATA_W-1:0] rw_rdata_p1;
  logic [DATA_W-1:0] r_rdata_p1 [RPORTS];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata_p1;

  logic              gnt_rw;
  logic              gnt_r [RPORTS];
  logic              r_found;
  logic [PTR_W-1:0]  r_sel;
  logic              r_elig [RPORTS];

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // Grant: load beats rw, rw beats the read ports, read ports rotate from the pointer.
  always_comb begin
    gnt_rw  = 1'b0;
    r_found = 1'b0;
    r_sel   = '0;
    for (int k = 0; k < RPORTS; k++) begin
      r_elig[k] = r_val[k] && (r_state_p1[k] == IDLE);
      gnt_r[k]  = 1'b0;
    end
    if (!ld_val_i) begin
      if (rw_val && (rw_state_p1 == IDLE)) begin
        gnt_rw = 1'b1;
      end else begin
        // Walk offsets downward so the smallest offset from the pointer wins.
        for (int i = RPORTS - 1; i >= 0; i--) begin
          if (r_elig[wrap_idx(int'(ptr_p1) + i)]) begin
            r_found = 1'b1;
            r_sel   = wrap_idx(int'(ptr_p1) + i);
          end
        end
        gnt_r[r_sel] = r_found;
      end
    end
    ptr_d = r_found ? wrap_idx(int'(r_sel) + 1) : ptr_p1;
  end

  always_comb begin
    ram_en    = arst_ni && (ld_val_i || gnt_rw || r_found);
    ram_we    = 1'b0;
    ram_addr  = ld_addr_i;
    ram_wdata = ld_data_i;
    if (ld_val_i) begin
      ram_we = 1'b1;
    end else if (gnt_rw) begin
      ram_we    = rw_wen;
      ram_addr  = rw_addr;
      ram_wdata = rw_wdata;
    end else if (r_found) begin
      ram_addr = r_addr[r_sel];
    end
  end

  always_comb begin
    rw_state_d = rw_state_p1;
    case (rw_state_p1)
      IDLE:    if (gnt_rw) rw_state_d = RESP;
      RESP:    rw_state_d = IDLE;
      default: rw_state_d = IDLE;
    endcase
    for (int k = 0; k < RPORTS; k++) begin
      r_state_d[k] = r_state_p1[k];
      case (r_state_p1[k])
        IDLE:    if (gnt_r[k]) r_state_d[k] = RESP;
        RESP:    r_state_d[k] = IDLE;
        default: r_state_d[k] = IDLE;
      endcase
    end
  end

  // Stage p1: RAM access and request latch at the grant edge; RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata_p1 <= mem[ram_addr];
    end
    if (gnt_rw) begin
      rw_addr_p1  <= rw_addr;
      rw_wen_p1   <= rw_wen;
      rw_wdata_p1 <= rw_wdata;
    end
    for (int k = 0; k < RPORTS; k++) begin
      if (gnt_r[k]) r_addr_p1[k] <= r_addr[k];
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rw_state_p1 <= IDLE;
      ptr_p1      <= '0;
      rw_rdata_p1 <= '0;
      for (int k = 0; k < RPORTS; k++) begin
        r_state_p1[k] <= IDLE;
        r_rdata_p1[k] <= '0;
      end
    end else begin
      rw_state_p1 <= rw_state_d;
      ptr_p1      <= ptr_d;
      if (rw_state_p1 == RESP) rw_rdata_p1 <= rw_rdata;
      for (int k = 0; k < RPORTS; k++) begin
        r_state_p1[k] <= r_state_d[k];
        if (r_state_p1[k] == RESP) r_rdata_p1[k] <= r_rdata[k];
      end
    end
  end

  // Only one port can be in RESP per cycle, so the shared RAM output register belongs to it.
  always_comb begin
    ld_rdy_o = arst_ni && ld_val_i;
    rw_rdy   = arst_ni && (rw_state_p1 == RESP) && rw_val && (rw_addr == rw_addr_p1) &&
               (rw_wen == rw_wen_p1) && (rw_wdata == rw_wdata_p1);
    rw_rdata = rw_rdata_p1;
    if (rw_state_p1 == RESP) rw_rdata = rw_wen_p1 ? rw_wdata_p1 : ram_rdata_p1;
    for (int k = 0; k < RPORTS; k++) begin
      r_rdy[k]   = arst_ni && (r_state_p1[k] == RESP) && r_val[k] &&
                   (r_addr[k] == r_addr_p1[k]);
      r_rdata[k] = (r_state_p1[k] == RESP) ? ram_rdata_p1 : r_rdata_p1[k];
    end
  end

endmodule
